uart_rx: RTL and testbench

//   Serial receiver for the host link. Clocked by the prescaler's clk_uart
//   (5x baud). Oversamples rx 5x per bit with 3-sample majority voting.

---
 rtl/uart_rx.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Purpose : 8N1 serial receiver, 5x oversampled, 3-sample majority vote per bit,
//           byte presented in a holding register with a valid/ack handshake.
// Latency : data/data_valid update 49 clk_uart cycles after IDLE sees rx_s low
//           (51 cycles from the rx pin falling edge, including the 2-flop synchronizer).
// Backpressure: none on the line; a byte completing while data_valid=1 and ack=0
//           is dropped and sets the sticky overrun flag.
//
// Ports:
//   clk_uart    in   1          receive clock, 5x baud
//   rst_n       in   1          asynchronous reset, active low
//   rx          in   1          asynchronous serial input, idles high
//   ack         in   1          consumer has taken data; only acts while data_valid=1
//   data        out  DATA_BITS  last accepted byte
//   data_valid  out  1          holding register full; held until ack
//   frame_err   out  1          one-cycle pulse when the stop bit votes low
//   overrun     out  1          sticky: byte completed while data_valid=1
//   busy        out  1          receiver is inside a frame (not IDLE)

module uart_rx #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk_uart,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 ack,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int              BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
   localparam logic [2:0]      PH_S1    = 3'd1;
   localparam logic [2:0]      PH_S2    = 3'd2;
   localparam logic [2:0]      PH_VOTE  = 3'd3;
   localparam logic [2:0]      PH_LAST  = 3'd4;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                 rx_meta_q, rx_meta_d;
   logic                 rx_s_q,    rx_s_d;
   state_t               state_q,   state_d;
   logic [2:0]           phase_q,   phase_d;
   logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
   logic                 samp1_q,   samp1_d;
   logic                 samp2_q,   samp2_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic [DATA_BITS-1:0] data_q,    data_d;
   logic                 data_valid_q, data_valid_d;
   logic                 frame_err_q,  frame_err_d;
   logic                 overrun_q,    overrun_d;
   logic                 busy_q,       busy_d;

   logic                 phase_wrap;
   logic                 majority;
   logic                 accept;

   // The third vote is the live synchronized sample at phase 3, so the
   // decision is available in the same cycle the last sample arrives.
   assign phase_wrap = (phase_q == PH_LAST);
   assign majority   = (samp1_q & samp2_q) | (samp1_q & rx_s_q) | (samp2_q & rx_s_q);

   // ---------------------------------------------------------------------
   // Synchronizer, bit timing and frame FSM
   // ---------------------------------------------------------------------
   always_comb begin
      rx_meta_d   = rx;
      rx_s_d      = rx_meta_q;
      state_d     = state_q;
      phase_d     = phase_wrap ? 3'd0 : (phase_q + 3'd1);
      bit_idx_d   = bit_idx_q;
      samp1_d     = samp1_q;
      samp2_d     = samp2_q;
      shift_d     = shift_q;
      accept      = 1'b0;
      frame_err_d = 1'b0;

      if (state_q != IDLE) begin
         if (phase_q == PH_S1) samp1_d = rx_s_q;
         if (phase_q == PH_S2) samp2_d = rx_s_q;
      end

      case (state_q)
         IDLE: begin
            // The cycle that first sees the line low is start phase 0.
            phase_d = 3'd0;
            if (!rx_s_q) begin
               state_d = START;
               phase_d = PH_S1;
            end
         end

         START: begin
            if (phase_q == PH_VOTE && majority) begin
               // Glitch, not a real start bit: drop back silently.
               state_d = IDLE;
               phase_d = 3'd0;
            end else if (phase_wrap) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end

         DATA: begin
            // Line order is LSB first; shifting in at the top and moving
            // right leaves the first received bit at position 0.
            if (phase_q == PH_VOTE) begin
               shift_d = {majority, shift_q[DATA_BITS-1:1]};
            end
            if (phase_wrap) begin
               if (bit_idx_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
               end
            end
         end

         STOP: begin
            // Leave at the vote rather than the end of the bit so a start
            // bit immediately following the stop bit is caught on time.
            if (phase_q == PH_VOTE) begin
               state_d = IDLE;
               phase_d = 3'd0;
               if (majority) begin
                  accept = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            phase_d = 3'd0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // ---------------------------------------------------------------------
   // Holding register and handshake
   // ---------------------------------------------------------------------
   always_comb begin
      data_d       = data_q;
      data_valid_d = data_valid_q;
      overrun_d    = overrun_q;

      if (accept) begin
         if (!data_valid_q || ack) begin
            // Either empty, or the old byte is consumed in this very cycle.
            data_d       = shift_q;
            data_valid_d = 1'b1;
            if (data_valid_q) overrun_d = 1'b0;
         end else begin
            // Consumer still holds the old byte: keep it, flag the loss.
            overrun_d = 1'b1;
         end
      end else if (ack && data_valid_q) begin
         data_valid_d = 1'b0;
         overrun_d    = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_uart or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         state_q      <= IDLE;
         phase_q      <= 3'd0;
         bit_idx_q    <= '0;
         samp1_q      <= 1'b1;
         samp2_q      <= 1'b1;
         shift_q      <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rx_meta_q    <= rx_meta_d;
         rx_s_q       <= rx_s_d;
         state_q      <= state_d;
         phase_q      <= phase_d;
         bit_idx_q    <= bit_idx_d;
         samp1_q      <= samp1_d;
         samp2_q      <= samp2_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
      end
   end

   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Purpose : bench for uart_rx; frame-level model predicts the holding register,
//           frame_err pulses and busy windows from line timing arithmetic.
// Latency : expected outputs change 51 edges after the rx pin falls for a frame.
// Backpressure: ack driven by the bench; overrun expected when bytes pile up.
`timescale 1ns/1ps
module tb_uart_rx;

   logic       clk_uart = 1'b0;
   logic       rst_n    = 1'b0;
   logic       rx       = 1'b1;
   logic       ack      = 1'b0;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx #(.DATA_BITS(8)) dut (
      .clk_uart   (clk_uart),
      .rst_n      (rst_n),
      .rx         (rx),
      .ack        (ack),
      .data       (data),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk_uart = ~clk_uart;

   // Frame-level events: at edge edge_n either a byte completes or a frame error pulses.
   typedef struct {
      int       edge_n;
      bit       is_err;
      logic [7:0] b;
   } ev_t;
   typedef struct {
      int s;
      int e;
   } iv_t;

   ev_t evq[$];
   iv_t busyq[$];

   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   cmp_en   = 1'b0;

   logic [7:0] exp_data = 8'h00;
   bit         exp_dv   = 1'b0;
   bit         exp_ovr  = 1'b0;
   bit         exp_ferr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
   endtask

   function automatic bit exp_busy();
      bit r;
      r = 1'b0;
      foreach (busyq[i]) if (busyq[i].s <= cyc && cyc < busyq[i].e) r = 1'b1;
      return r;
   endfunction

   // Model: holding-register rules applied at each clock edge, driven by the
   // frame events the stimulus scheduled. cyc counts edges out of reset.
   always @(posedge clk_uart or negedge rst_n) begin
      bit         acc;
      bit         err;
      logic [7:0] nb;
      if (!rst_n) begin
         exp_data = 8'h00;
         exp_dv   = 1'b0;
         exp_ovr  = 1'b0;
         exp_ferr = 1'b0;
      end else begin
         cyc = cyc + 1;
         acc = 1'b0;
         err = 1'b0;
         nb  = 8'h00;
         foreach (evq[i]) begin
            if (evq[i].edge_n == cyc) begin
               if (evq[i].is_err) err = 1'b1;
               else begin
                  acc = 1'b1;
                  nb  = evq[i].b;
               end
            end
         end
         exp_ferr = err;
         if (acc) begin
            if (!exp_dv || ack) begin
               if (exp_dv) exp_ovr = 1'b0;
               exp_data = nb;
               exp_dv   = 1'b1;
            end else begin
               exp_ovr = 1'b1;
            end
         end else if (ack && exp_dv) begin
            exp_dv  = 1'b0;
            exp_ovr = 1'b0;
         end
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk_uart) begin
      if (cmp_en) begin
         check("data",       data,       exp_data);
         check("data_valid", data_valid, exp_dv);
         check("frame_err",  frame_err,  exp_ferr);
         check("overrun",    overrun,    exp_ovr);
         check("busy",       busy,       exp_busy());
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_uart); #1;
      end
   endtask

   task automatic do_ack();
      @(posedge clk_uart); #1; ack = 1'b1;
      @(posedge clk_uart); #1; ack = 1'b0;
   endtask

   // Drives ncyc line cycles of a 50-cycle 8N1 frame (5 cycles per bit).
   // glitch inverts the third cycle of every bit; stop_low pulls the stop bit
   // low for its first four cycles. ack_acc raises ack over the accept edge.
   task automatic send_frame(input logic [7:0] b, input bit glitch, input bit stop_low,
                             input int ncyc, input bit ack_acc, output int e);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      e = 0;
      for (int k = 0; k < ncyc; k++) begin
         int   j;
         int   t;
         logic v;
         @(posedge clk_uart); #1;
         j = k / 5;
         t = k % 5;
         if (k == 0) begin
            e = cyc;
            busyq.push_back('{e + 3, e + 51});
         end
         v = bits[j];
         if (glitch && t == 2) v = ~v;
         if (j == 9 && stop_low) v = (t == 4);
         rx = v;
      end
      if (ncyc == 50) evq.push_back('{e + 51, stop_low, b});
      if (ack_acc) begin
         @(posedge clk_uart); #1; ack = 1'b1;
         @(posedge clk_uart); #1; ack = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int e;
      int cnt;
      int rise;

      rst_n = 1'b0;
      rx    = 1'b1;
      ack   = 1'b0;
      repeat (3) @(posedge clk_uart);
      #1;
      cmp_en = 1'b1;
      check("rst_data",  data,       32'h0);
      check("rst_valid", data_valid, 32'h0);
      check("rst_ferr",  frame_err,  32'h0);
      check("rst_ovr",   overrun,    32'h0);
      check("rst_busy",  busy,       32'h0);
      rst_n = 1'b1;
      idle(5);

      // 1: clean 0x55, latency pinned to 51 edges from the pin edge.
      send_frame(8'h55, 1'b0, 1'b0, 50, 1'b0, e);
      rise = -1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_uart); #1;
         if (data_valid && rise < 0) rise = cyc;
      end
      check("t1_latency", rise,    e + 51);
      check("t1_data",    data,    32'h55);
      check("t1_ovr",     overrun, 32'h0);
      do_ack();
      idle(3);

      // 2: one inverted sample per bit is outvoted.
      send_frame(8'hA3, 1'b1, 1'b0, 50, 1'b0, e);
      idle(3);
      check("t2_data",  data,       32'hA3);
      check("t2_valid", data_valid, 32'h1);
      do_ack();
      idle(3);

      // 3: false start, two low cycles only.
      @(posedge clk_uart); #1;
      e  = cyc;
      rx = 1'b0;
      busyq.push_back('{e + 3, e + 6});
      @(posedge clk_uart); #1;
      @(posedge clk_uart); #1;
      rx = 1'b1;
      while (cyc < e + 4) begin
         @(posedge clk_uart); #1;
      end
      check("t3_busy_hi", busy, 32'h1);
      cnt = 0;
      while (cyc < e + 10) begin
         @(posedge clk_uart); #1;
         cnt += int'(frame_err) + int'(data_valid);
      end
      check("t3_busy_lo",   busy, 32'h0);
      check("t3_no_output", cnt,  32'h0);

      // 4: stop bit low -> single frame_err pulse, holding register untouched.
      send_frame(8'h3C, 1'b0, 1'b1, 50, 1'b0, e);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_uart); #1;
         cnt += int'(frame_err);
      end
      check("t4_ferr_pulses", cnt,        32'h1);
      check("t4_valid",       data_valid, 32'h0);
      check("t4_data",        data,       32'hA3);

      // 5: overrun, ack clear, ack coinciding with accept.
      send_frame(8'h11, 1'b0, 1'b0, 50, 1'b0, e);
      send_frame(8'h22, 1'b0, 1'b0, 50, 1'b0, e);
      idle(3);
      check("t5_data_kept", data,       32'h11);
      check("t5_ovr_set",   overrun,    32'h1);
      check("t5_valid",     data_valid, 32'h1);
      do_ack();
      check("t5_ack_valid", data_valid, 32'h0);
      check("t5_ack_ovr",   overrun,    32'h0);
      send_frame(8'h33, 1'b0, 1'b0, 50, 1'b1, e);
      check("t5_33_data",  data,       32'h33);
      check("t5_33_valid", data_valid, 32'h1);
      check("t5_33_ovr",   overrun,    32'h0);
      send_frame(8'h5A, 1'b0, 1'b0, 50, 1'b0, e);
      idle(3);
      check("t5_5a_ovr",  overrun, 32'h1);
      check("t5_5a_data", data,    32'h33);
      send_frame(8'h44, 1'b0, 1'b0, 50, 1'b1, e);
      check("t5_44_data",  data,       32'h44);
      check("t5_44_valid", data_valid, 32'h1);
      check("t5_44_ovr",   overrun,    32'h0);
      do_ack();
      idle(3);

      // 6: reset in data bit 4 of 0x9A, then a clean 0x7E.
      send_frame(8'h9A, 1'b0, 1'b0, 29, 1'b0, e);
      rx    = 1'b1;
      rst_n = 1'b0;
      evq.delete();
      busyq.delete();
      #2;
      check("t6_rst_data",  data,       32'h0);
      check("t6_rst_valid", data_valid, 32'h0);
      check("t6_rst_busy",  busy,       32'h0);
      check("t6_rst_ovr",   overrun,    32'h0);
      repeat (4) @(posedge clk_uart);
      #1;
      rst_n = 1'b1;
      idle(10);
      send_frame(8'h7E, 1'b0, 1'b0, 50, 1'b0, e);
      idle(3);
      check("t6_data",  data,       32'h7E);
      check("t6_valid", data_valid, 32'h1);
      check("t6_ovr",   overrun,    32'h0);
      idle(5);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
